dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests produced by the CPU memory stage: doubleword address, 64-bit write data, 8-bit byte-enable mask.
Holds a DEPTH x 64-bit backing store and answers each request after a fixed, programmable latency over a valid/ready request and response handshake.
Returns the full aligned 64-bit doubleword on reads; byte selection and sign extension remain in the memory stage.
Single outstanding request; sits between the memory stage and the simulation top level.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the CPU memory stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_byte_enable;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_byte_enable, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_byte_enable, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: DEPTH x 64-bit data memory answering one request at a time
// after a fixed LATENCY (1..15) over valid/ready request and response channels.
// Loads return the whole aligned doubleword; stores are merged per byte lane.
// Optional build macro DMEM_BE_CHECK_EN: when defined, store masks outside the
// set of naturally aligned 1/2/4/8-byte lanes (or all-zero) are rejected with
// resp_err=1 and no write. Timing is the same in both builds.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_W  = 61 - IDX_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Legal store masks: full word, aligned halves, aligned pairs, single bytes, none.
  function automatic logic be_legal(input logic [7:0] be);
    logic ok;
    case (be)
      8'hFF, 8'h0F, 8'hF0,
      8'h03, 8'h0C, 8'h30, 8'hC0,
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h00:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [63:0] r_resp_rdata;
  logic [63:0] r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_accept;
  logic             w_be_ok;
  logic             w_wr_en;
  logic             w_err;
  logic [2:0]       w_unused_addr_bits;

  assign w_idx              = bus.req_addr[IDX_W+2:3];
  assign w_in_range         = (bus.req_addr[63:IDX_W+3] == {HI_W{1'b0}});
  assign w_accept           = bus.req_valid & r_req_ready;
  assign w_unused_addr_bits = bus.req_addr[2:0];

  // Mask legality for stores; loads ignore the mask entirely.
  always_comb begin
    w_be_ok = 1'b1;
`ifdef DMEM_BE_CHECK_EN
    if (bus.req_wen) begin
      w_be_ok = be_legal(bus.req_byte_enable);
    end else begin
      w_be_ok = 1'b1;
    end
`else
    w_be_ok = 1'b1;
`endif
  end

  assign w_wr_en = w_accept & bus.req_wen & w_in_range & w_be_ok;
  assign w_err   = ~w_in_range | (bus.req_wen & ~w_be_ok);

  // Backing store: byte-lane merge at the accept edge (array is never reset).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_wr_en && bus.req_byte_enable[i]) begin
        r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM: accept, count down the latency, hold the response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_resp_err   <= w_err;
            // Only an in-range load returns data; stores and errors return zero.
            r_resp_rdata <= (!bus.req_wen && w_in_range) ? r_mem[w_idx] : 64'd0;
            if (LATENCY == 1) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_cnt   <= LAT_M1;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd1) begin
            r_cnt        <= 4'd0;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Handshake frees the responder; the next accept is a cycle later.
          if (bus.resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= 4'd0;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 64'd0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench for dmem_responder (DEPTH=1024,
// LATENCY=2). Expected values are hand-computed; DMEM_BE_CHECK_EN selects the
// mask-check expectations.
module tb_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
`ifdef DMEM_BE_CHECK_EN
  localparam bit BE_CHK = 1'b1;
`else
  localparam bit BE_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if u_bus ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: request, latency measurement, optional hold, handshake.
  task automatic do_req(input string tag, input logic [63:0] addr, input logic wen,
                        input logic [63:0] wdata, input logic [7:0] be, input int hold,
                        input logic [63:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    check_val({tag, "/req_ready_idle"}, 64'(u_bus.req_ready), 64'd1);
    u_bus.req_addr        = addr;
    u_bus.req_wen         = wen;
    u_bus.req_wdata       = wdata;
    u_bus.req_byte_enable = be;
    u_bus.req_valid       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs while busy; they must not matter.
    u_bus.req_valid       = 1'b0;
    u_bus.req_addr        = 64'h10;
    u_bus.req_wen         = ~wen;
    u_bus.req_wdata       = ~wdata;
    u_bus.req_byte_enable = 8'hFF;
    check_val({tag, "/req_ready_busy"}, 64'(u_bus.req_ready), 64'd0);
    n = 1;
    while (!u_bus.resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "/latency"}, 64'(n), 64'(LATENCY));
    check_val({tag, "/rdata"}, u_bus.resp_rdata, exp_rdata);
    check_val({tag, "/err"}, 64'(u_bus.resp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "/hold_valid"}, 64'(u_bus.resp_valid), 64'd1);
      check_val({tag, "/hold_rdata"}, u_bus.resp_rdata, exp_rdata);
      check_val({tag, "/hold_err"}, 64'(u_bus.resp_err), 64'(exp_err));
      check_val({tag, "/hold_req_ready"}, 64'(u_bus.req_ready), 64'd0);
    end
    u_bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_bus.resp_ready = 1'b0;
    check_val({tag, "/req_ready_after"}, 64'(u_bus.req_ready), 64'd1);
    check_val({tag, "/valid_after"}, 64'(u_bus.resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_bus.req_valid       = 1'b0;
    u_bus.req_addr        = 64'd0;
    u_bus.req_wen         = 1'b0;
    u_bus.req_wdata       = 64'd0;
    u_bus.req_byte_enable = 8'h00;
    u_bus.resp_ready      = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst/req_ready", 64'(u_bus.req_ready), 64'd1);
    check_val("rst/resp_valid", 64'(u_bus.resp_valid), 64'd0);
    check_val("rst/resp_rdata", u_bus.resp_rdata, 64'd0);
    check_val("rst/resp_err", 64'(u_bus.resp_err), 64'd0);

    // Basic store/load and byte-lane merge.
    do_req("st10",   64'h10, 1'b1, 64'h1122334455667788, 8'hFF, 0, 64'd0, 1'b0);
    do_req("ld10",   64'h10, 1'b0, 64'd0,                8'hFF, 0, 64'h1122334455667788, 1'b0);
    do_req("st13",   64'h13, 1'b1, 64'h00000000AB000000, 8'h08, 0, 64'd0, 1'b0);
    do_req("ld10b",  64'h10, 1'b0, 64'd0,                8'h00, 0, 64'h11223344AB667788, 1'b0);

    // Out-of-range requests must not alias onto word 0 or touch any word.
    do_req("st00",   64'h0,    1'b1, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 0, 64'd0, 1'b0);
    do_req("stlast", 64'h1FF8, 1'b1, 64'h0102030405060708, 8'hFF, 0, 64'd0, 1'b0);
    do_req("ld_oor", 64'h2000, 1'b0, 64'd0,                8'hFF, 0, 64'd0, 1'b1);
    do_req("st_oor", 64'h2000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'd0, 1'b1);
    do_req("st_hi",  64'h8000000000000000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'd0, 1'b1);
    do_req("ld00",   64'h0,    1'b0, 64'd0, 8'hFF, 0, 64'hA5A5A5A5A5A5A5A5, 1'b0);
    do_req("ldlast", 64'h1FFF, 1'b0, 64'd0, 8'hFF, 0, 64'h0102030405060708, 1'b0);
    do_req("ld10c",  64'h10,   1'b0, 64'd0, 8'hFF, 0, 64'h11223344AB667788, 1'b0);

    // Response back-pressure.
    do_req("ld_hold", 64'h10, 1'b0, 64'd0, 8'hFF, 5, 64'h11223344AB667788, 1'b0);

    // Mask handling, build-dependent.
    do_req("st18",      64'h18, 1'b1, 64'd0,                8'hFF, 0, 64'd0, 1'b0);
    do_req("st18_be06", 64'h18, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'h06, 0, 64'd0, BE_CHK);
    do_req("ld18a",     64'h18, 1'b0, 64'd0, 8'h00, 0,
           BE_CHK ? 64'h0 : 64'h0000000000FFFF00, 1'b0);
    do_req("st18_be0C", 64'h18, 1'b1, 64'h1111111111111111, 8'h0C, 0, 64'd0, 1'b0);
    do_req("ld18b",     64'h18, 1'b0, 64'd0, 8'h00, 0,
           BE_CHK ? 64'h0000000011110000 : 64'h000000001111FF00, 1'b0);
    do_req("st18_be00", 64'h18, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 64'd0, 1'b0);
    do_req("ld18c",     64'h18, 1'b0, 64'd0, 8'h00, 0,
           BE_CHK ? 64'h0000000011110000 : 64'h000000001111FF00, 1'b0);

    // Reset while BUSY: response dropped, accepted store stays committed.
    @(negedge clk);
    check_val("rstbusy/req_ready_idle", 64'(u_bus.req_ready), 64'd1);
    u_bus.req_addr        = 64'h8;
    u_bus.req_wen         = 1'b1;
    u_bus.req_wdata       = 64'hDEAD;
    u_bus.req_byte_enable = 8'hFF;
    u_bus.req_valid       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rstbusy/req_ready", 64'(u_bus.req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_val("rstbusy/resp_valid", 64'(u_bus.resp_valid), 64'd0);
      @(negedge clk);
    end
    do_req("ld08", 64'h8, 1'b0, 64'd0, 8'hFF, 0, 64'hDEAD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
